branch_resolve_ctrl: RTL and testbench
======================================

# branch_resolve_ctrl

Sequencer for branch resolution in the execute stage. It accepts one branch request at a time from decode, evaluates the comparison and the PC-relative target, and decides taken or not-taken. For a taken branch it signals a pipeline flush and holds a PC redirect toward fetch until fetch accepts it. It owns the branch compare/target datapath internally and keeps a saturating count of taken branches for performance monitoring.

## Interface
- PC_W, 32, PC/operand width
- OFF_W, 16, branch offset width (word offset, sign-extended)
- CNT_W, 16, taken-branch counter width

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- br_valid  in  1  decode presents a branch request
- br_ready  out  1  controller can accept a request (high only in IDLE)
- br_op  in  2  00 BEQ, 01 BNE, 10 BR (unconditional relative), 11 reserved
- br_pc  in  PC_W  PC used as the target base
- br_a, br_b  in  PC_W  operands to compare
- br_offset  in  OFF_W  signed word offset
- redir_valid  out  1  redirect target pending toward fetch
- redir_ready  in  1  fetch accepts the redirect
- redir_target  out  PC_W  registered branch target
- resolved  out  1  one-cycle pulse: a branch finished evaluation
- taken  out  1  qualifies resolved: branch taken
- flush  out  1  one-cycle pulse: squash younger instructions
- illegal  out  1  one-cycle pulse: br_op == 11 was evaluated
- taken_count  out  CNT_W  saturating count of taken branches

## Operation
- States: IDLE, EVAL, REDIRECT.
- IDLE
  - br_ready = 1.
  - When br_valid & br_ready, capture br_op, br_pc, br_a, br_b and br_offset into internal registers, then go to EVAL.
- EVAL
  - zero = (a == b).
  - target = pc + (sext(offset) << 2), computed modulo 2^PC_W. Wrap-around is silent.
  - Taken decision:
    - BEQ: taken = zero.
    - BNE: taken = !zero.
    - BR: taken = 1.
    - 11: taken = 0 and illegal is raised.
  - Register the target into redir_target and register the pulse outputs.
  - Next state is REDIRECT if taken, otherwise IDLE.
- REDIRECT
  - redir_valid = 1.
  - redir_target is held stable.
  - br_ready = 0 and new requests are ignored.
  - On redir_valid & redir_ready, go to IDLE.
  - redir_ready seen in any other state is ignored.
- taken_count increments by 1 on each taken resolution and saturates at all-ones. It does not wrap.
- Inputs other than those captured on the accept edge are don't-care outside IDLE.

## Timing
- Reset values:
  - state = IDLE, br_ready = 1.
  - redir_valid = 0, redir_target = 0.
  - resolved = 0, taken = 0, flush = 0, illegal = 0.
  - taken_count = 0.
- Accept edge is at the end of cycle T. Cycle T+1 is EVAL.
- Cycle T+2:
  - resolved = 1 for exactly one cycle.
  - taken = the decision, valid only while resolved = 1, otherwise 0.
  - flush = resolved & taken.
  - illegal pulses in the same cycle as resolved.
  - taken_count shows its new value.
- Not-taken branch: state is IDLE at T+2, so br_ready = 1 during the resolved cycle. Minimum issue interval is 2 cycles.
- Taken branch: redir_valid rises at T+2 and stays high until the handshake.
  - If redir_ready = 1 at T+2, the transfer completes that cycle, redir_valid = 0 and br_ready = 1 at T+3. Minimum issue interval is 3 cycles.
- redir_target changes only on an EVAL edge. It is stable from T+2 until the next EVAL.
- Reset asserted in any state, including mid-REDIRECT:
  - Next cycle returns to IDLE with all reset values.
  - The pending redirect is dropped and no pulses are emitted.
- Simultaneous br_valid and a completing redirect handshake in REDIRECT: the request is not accepted (br_ready = 0). It is accepted no earlier than the following IDLE cycle.

## Test plan
- BEQ, pc=0x100, a=b=1, offset=0x0004, redir_ready=1 -> at T+2: resolved=1, taken=1, flush=1, redir_valid=1, redir_target=0x00000110, taken_count=1. At T+3: br_ready=1.
- BNE, pc=0x100, a=1, b=2, offset=0x0004 -> resolved=1, taken=1, target=0x00000110. Repeat with a=b=2 -> taken=0, flush=0, redir_valid stays 0, br_ready=1 at T+2.
- BEQ, pc=0x200, a=b=2, offset=0xFFFC, redir_ready held 0 for 5 cycles -> redir_valid=1 and target=0x000001F0 held stable for 5 cycles. br_valid is ignored throughout. Release redir_ready -> IDLE next cycle.
- BR, pc=0xFFFFFFFC, offset=0x0002 -> target=0x00000004 (wrap), taken=1. Then br_op=11 -> resolved=1, illegal=1, taken=0, no redirect.
- Reset during REDIRECT (target pending) -> next cycle redir_valid=0, br_ready=1, taken_count=0, no pulses.
- Force taken_count to 0xFFFE, then issue 3 taken BR branches -> count reads 0xFFFF, 0xFFFF, 0xFFFF (saturates).

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// Execute-stage branch resolution sequencer: captures one branch, evaluates
// compare and PC-relative target, pulses the result and holds a redirect until fetch takes it.
module branch_resolve_ctrl #(
    parameter int PC_W  = 32,
    parameter int OFF_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [1:0]       br_op,
    input  logic [PC_W-1:0]  br_pc,
    input  logic [PC_W-1:0]  br_a,
    input  logic [PC_W-1:0]  br_b,
    input  logic [OFF_W-1:0] br_offset,
    output logic             redir_valid,
    input  logic             redir_ready,
    output logic [PC_W-1:0]  redir_target,
    output logic             resolved,
    output logic             taken,
    output logic             flush,
    output logic             illegal,
    output logic [CNT_W-1:0] taken_count
);

    typedef enum logic [1:0] {IDLE, EVAL, REDIRECT} state_t;

    typedef struct packed {
        logic [1:0]       op;
        logic [PC_W-1:0]  pc;
        logic [PC_W-1:0]  a;
        logic [PC_W-1:0]  b;
        logic [OFF_W-1:0] offset;
    } br_req_t;

    localparam logic [1:0]       OP_BEQ  = 2'b00;
    localparam logic [1:0]       OP_BNE  = 2'b01;
    localparam logic [1:0]       OP_BR   = 2'b10;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t          state, state_next;
    br_req_t         req;
    logic            zero;
    logic            take;
    logic            bad_op;
    logic [PC_W-1:0] off_ext;
    logic [PC_W-1:0] target;

    // Compare / target datapath, only meaningful while in EVAL
    always_comb begin
        zero    = (req.a == req.b);
        off_ext = {{(PC_W-OFF_W){req.offset[OFF_W-1]}}, req.offset};
        target  = req.pc + (off_ext << 2);
        take    = 1'b0;
        bad_op  = 1'b0;
        case (req.op)
            OP_BEQ:  take = zero;
            OP_BNE:  take = !zero;
            OP_BR:   take = 1'b1;
            default: bad_op = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        br_ready    = 1'b0;
        redir_valid = 1'b0;
        case (state)
            IDLE: begin
                br_ready = 1'b1;
                if (br_valid) state_next = EVAL;
            end
            EVAL: state_next = take ? REDIRECT : IDLE;
            REDIRECT: begin
                redir_valid = 1'b1;
                if (redir_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request capture, registered result pulses and the saturating taken counter
    always_ff @(posedge clk) begin
        if (reset) begin
            req          <= '0;
            redir_target <= '0;
            resolved     <= 1'b0;
            taken        <= 1'b0;
            flush        <= 1'b0;
            illegal      <= 1'b0;
            taken_count  <= '0;
        end else begin
            resolved <= 1'b0;
            taken    <= 1'b0;
            flush    <= 1'b0;
            illegal  <= 1'b0;
            if (state == IDLE && br_valid) begin
                req <= '{op: br_op, pc: br_pc, a: br_a, b: br_b, offset: br_offset};
            end
            if (state == EVAL) begin
                redir_target <= target;
                resolved     <= 1'b1;
                taken        <= take;
                flush        <= take;
                illegal      <= bad_op;
                if (take && taken_count != '1) taken_count <= taken_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: a transaction-level model is checked every cycle,
// with literal expectations at key points; a 2-bit-counter twin exercises saturation.
module tb_branch_resolve_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        br_valid;
    logic [1:0]  br_op;
    logic [31:0] br_pc, br_a, br_b;
    logic [15:0] br_offset;
    logic        redir_ready;

    logic        br_ready, redir_valid, resolved, taken, flush, illegal;
    logic [31:0] redir_target;
    logic [15:0] taken_count;

    logic        s_br_ready, s_redir_valid, s_resolved, s_taken, s_flush, s_illegal;
    logic [31:0] s_redir_target;
    logic [1:0]  s_taken_count;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(.PC_W(32), .OFF_W(16), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .br_valid(br_valid), .br_ready(br_ready),
        .br_op(br_op), .br_pc(br_pc), .br_a(br_a), .br_b(br_b), .br_offset(br_offset),
        .redir_valid(redir_valid), .redir_ready(redir_ready), .redir_target(redir_target),
        .resolved(resolved), .taken(taken), .flush(flush), .illegal(illegal),
        .taken_count(taken_count)
    );

    branch_resolve_ctrl #(.PC_W(32), .OFF_W(16), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .br_valid(br_valid), .br_ready(s_br_ready),
        .br_op(br_op), .br_pc(br_pc), .br_a(br_a), .br_b(br_b), .br_offset(br_offset),
        .redir_valid(s_redir_valid), .redir_ready(redir_ready), .redir_target(s_redir_target),
        .resolved(s_resolved), .taken(s_taken), .flush(s_flush), .illegal(s_illegal),
        .taken_count(s_taken_count)
    );

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] calc_target(logic [31:0] pc, logic [15:0] off);
        longint t;
        t = longint'(pc) + longint'($signed(off)) * 4;
        return t[31:0];
    endfunction

    function automatic logic calc_taken(logic [1:0] op, logic [31:0] a, logic [31:0] b);
        case (op)
            2'd0:    return a == b;
            2'd1:    return a != b;
            2'd2:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    logic        m_ready, m_rvalid, m_res, m_tk, m_fl, m_il, m_pend;
    logic [31:0] m_target;
    int          m_cnt, m_cnt_s;
    logic [1:0]  q_op;
    logic [31:0] q_pc, q_a, q_b;
    logic [15:0] q_off;

    always @(posedge clk) begin
        if (reset) begin
            m_ready <= 1; m_rvalid <= 0; m_target <= 0; m_pend <= 0;
            m_res <= 0; m_tk <= 0; m_fl <= 0; m_il <= 0;
            m_cnt <= 0; m_cnt_s <= 0;
        end else begin
            m_res <= 0; m_tk <= 0; m_fl <= 0; m_il <= 0;
            if (m_pend) begin
                m_pend   <= 0;
                m_res    <= 1;
                m_tk     <= calc_taken(q_op, q_a, q_b);
                m_fl     <= calc_taken(q_op, q_a, q_b);
                m_il     <= (q_op == 2'd3);
                m_target <= calc_target(q_pc, q_off);
                m_rvalid <= calc_taken(q_op, q_a, q_b);
                m_ready  <= !calc_taken(q_op, q_a, q_b);
                if (calc_taken(q_op, q_a, q_b)) begin
                    if (m_cnt < 65535) m_cnt <= m_cnt + 1;
                    if (m_cnt_s < 3)   m_cnt_s <= m_cnt_s + 1;
                end
            end else if (m_rvalid) begin
                if (redir_ready) begin
                    m_rvalid <= 0;
                    m_ready  <= 1;
                end
            end else if (br_valid) begin
                q_op <= br_op; q_pc <= br_pc; q_a <= br_a; q_b <= br_b; q_off <= br_offset;
                m_pend  <= 1;
                m_ready <= 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("br_ready",      32'(br_ready),      32'(m_ready));
            chk("redir_valid",   32'(redir_valid),   32'(m_rvalid));
            chk("redir_target",  redir_target,       m_target);
            chk("resolved",      32'(resolved),      32'(m_res));
            chk("taken",         32'(taken),         32'(m_tk));
            chk("flush",         32'(flush),         32'(m_fl));
            chk("illegal",       32'(illegal),       32'(m_il));
            chk("taken_count",   32'(taken_count),   32'(m_cnt));
            chk("s_br_ready",    32'(s_br_ready),    32'(m_ready));
            chk("s_redir_valid", 32'(s_redir_valid), 32'(m_rvalid));
            chk("s_redir_target", s_redir_target,    m_target);
            chk("s_resolved",    32'(s_resolved),    32'(m_res));
            chk("s_taken",       32'(s_taken),       32'(m_tk));
            chk("s_flush",       32'(s_flush),       32'(m_fl));
            chk("s_illegal",     32'(s_illegal),     32'(m_il));
            chk("s_taken_count", 32'(s_taken_count), 32'(m_cnt_s));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b, input logic [15:0] off);
        br_valid = v; br_op = op; br_pc = pc; br_a = a; br_b = b; br_offset = off;
    endtask

    initial begin
        reset = 1'b1; redir_ready = 1'b0;
        drive(0, 2'd0, 0, 0, 0, 0);
        cyc();
        chk_en = 1'b1;
        @(negedge clk);
        chk("lit_rst_ready", 32'(br_ready), 1);
        chk("lit_rst_rvalid", 32'(redir_valid), 0);
        chk("lit_rst_target", redir_target, 0);
        chk("lit_rst_count", 32'(taken_count), 0);
        reset = 1'b0;
        cyc();

        // BEQ taken, fetch ready immediately
        drive(1, 2'd0, 32'h100, 1, 1, 16'h0004); redir_ready = 1'b1;
        cyc(); br_valid = 0;
        cyc(); @(negedge clk);
        chk("lit_beq_res", 32'(resolved), 1);
        chk("lit_beq_taken", 32'(taken), 1);
        chk("lit_beq_flush", 32'(flush), 1);
        chk("lit_beq_rvalid", 32'(redir_valid), 1);
        chk("lit_beq_target", redir_target, 32'h110);
        chk("lit_beq_count", 32'(taken_count), 1);
        cyc(); @(negedge clk);
        chk("lit_beq_ready_t3", 32'(br_ready), 1);

        // BNE taken, then BNE not taken
        drive(1, 2'd1, 32'h100, 1, 2, 16'h0004);
        cyc(); br_valid = 0;
        cyc(); @(negedge clk);
        chk("lit_bne_taken", 32'(taken), 1);
        chk("lit_bne_target", redir_target, 32'h110);
        cyc();
        drive(1, 2'd1, 32'h100, 2, 2, 16'h0004);
        cyc(); br_valid = 0;
        cyc(); @(negedge clk);
        chk("lit_bnent_res", 32'(resolved), 1);
        chk("lit_bnent_taken", 32'(taken), 0);
        chk("lit_bnent_flush", 32'(flush), 0);
        chk("lit_bnent_rvalid", 32'(redir_valid), 0);
        chk("lit_bnent_ready", 32'(br_ready), 1);

        // back-to-back not-taken at the 2-cycle issue interval
        drive(1, 2'd0, 32'h40, 1, 2, 16'h0010);
        repeat (4) cyc();
        br_valid = 0;
        @(negedge clk);
        chk("lit_b2b_res", 32'(resolved), 1);
        chk("lit_b2b_count", 32'(taken_count), 2);
        cyc();

        // negative offset, fetch stalls 5 cycles, decode keeps presenting a request
        drive(1, 2'd0, 32'h200, 2, 2, 16'hFFFC); redir_ready = 1'b0;
        cyc();
        drive(1, 2'd1, 32'h300, 5, 5, 16'h0008);
        cyc();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("lit_hold_rvalid", 32'(redir_valid), 1);
            chk("lit_hold_target", redir_target, 32'h1F0);
            chk("lit_hold_ready", 32'(br_ready), 0);
            cyc();
        end
        redir_ready = 1'b1;
        @(negedge clk);
        chk("lit_hs_ready", 32'(br_ready), 0);
        cyc(); @(negedge clk);
        chk("lit_post_ready", 32'(br_ready), 1);
        chk("lit_post_rvalid", 32'(redir_valid), 0);
        cyc(); br_valid = 0;
        cyc(); @(negedge clk);
        chk("lit_late_res", 32'(resolved), 1);
        chk("lit_late_target", redir_target, 32'h320);
        chk("lit_late_count", 32'(taken_count), 3);

        // BR wrapping target, then reserved op
        drive(1, 2'd2, 32'hFFFF_FFFC, 0, 0, 16'h0002);
        cyc(); br_valid = 0;
        cyc(); @(negedge clk);
        chk("lit_wrap_target", redir_target, 32'h4);
        chk("lit_wrap_taken", 32'(taken), 1);
        cyc();
        drive(1, 2'd3, 32'h10, 7, 7, 16'h0001);
        cyc(); br_valid = 0;
        cyc(); @(negedge clk);
        chk("lit_ill_res", 32'(resolved), 1);
        chk("lit_ill_illegal", 32'(illegal), 1);
        chk("lit_ill_taken", 32'(taken), 0);
        chk("lit_ill_rvalid", 32'(redir_valid), 0);
        cyc();

        // reset while a redirect is pending
        drive(1, 2'd0, 32'h80, 3, 3, 16'h0020); redir_ready = 1'b0;
        cyc(); br_valid = 0;
        cyc(); @(negedge clk);
        chk("lit_prerst_rvalid", 32'(redir_valid), 1);
        chk("lit_prerst_target", redir_target, 32'h100);
        reset = 1'b1;
        cyc(); @(negedge clk);
        chk("lit_midrst_rvalid", 32'(redir_valid), 0);
        chk("lit_midrst_ready", 32'(br_ready), 1);
        chk("lit_midrst_count", 32'(taken_count), 0);
        chk("lit_midrst_res", 32'(resolved), 0);
        reset = 1'b0;
        cyc();

        // saturation: the 2-bit twin pins at all-ones while the wide counter keeps going
        redir_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1, 2'd2, 32'h1000, 0, 0, 16'h0001);
            cyc(); br_valid = 0;
            cyc(); @(negedge clk);
            chk("lit_sat_target", redir_target, 32'h1004);
            chk("lit_sat_count", 32'(taken_count), 32'(i + 1));
            chk("lit_sat_count_s", 32'(s_taken_count), (i >= 2) ? 32'd3 : 32'(i + 1));
            cyc();
        end

        repeat (3) cyc();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
